pc_update_ctrl: RTL and testbench

Sequencing controller for the MiniRISC program-counter path. It accepts one decoded control-flow instruction at a time and selects the offset field width (16/22/28 bits). It sign-extends that field, evaluates the branch condition and computes the next PC. It presents the result to the fetch stage with a valid/stall handshake and optionally produces a link-register write for call instructions.

---
 rtl/pc_update_ctrl_if.sv | 27 ++
 rtl/pc_update_ctrl.sv | 149 ++++++++++++++
 tb/tb_pc_update_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_update_ctrl_if.sv
// Instruction-in / next-PC-out bundle between decode, the PC update controller and fetch.
// master drives the decoded instruction and stall; slave is the controller.
interface pc_update_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  off_sel;
  logic [2:0]  cond;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic        carry;
  logic        stall;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        taken;
  logic        link_we;
  logic [31:0] link_val;

  modport master (
    output instr_valid, off_sel, cond, instr, rs_val, carry, stall,
    input  instr_ready, pc_out, pc_valid, taken, link_we, link_val
  );

  modport slave (
    input  instr_valid, off_sel, cond, instr, rs_val, carry, stall,
    output instr_ready, pc_out, pc_valid, taken, link_we, link_val
  );
endinterface

// File: rtl/pc_update_ctrl.sv
// Next-PC controller: IDLE captures one instruction, EVAL computes the target, UPDATE holds it while stall=1.
// pc_valid follows acceptance by one EVAL cycle; define PCU_LINK_EN for the cond=111 link-register write.
module pc_update_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  pc_update_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_sel_q, off_sel_d;
  logic [2:0]  cond_q, cond_d;
  logic [27:0] instr_q, instr_d;
  logic [31:0] rs_val_q, rs_val_d;
  logic        carry_q, carry_d;
  logic [31:0] pc_q, pc_d;
  logic        taken_q, taken_d;
  logic        pc_valid_q, pc_valid_d;
  logic        instr_ready_q, instr_ready_d;

  logic [31:0] ext_off;
  logic [31:0] seq_pc;
  logic        cond_met;
  logic [3:0]  unused_instr_hi;

  assign unused_instr_hi = bus.instr[31:28];
  assign seq_pc          = pc_q + 32'd4;

  always_comb begin
    ext_off = 32'd0;
    case (off_sel_q)
      2'b01:   ext_off = {{16{instr_q[15]}}, instr_q[15:0]};
      2'b10:   ext_off = {{10{instr_q[21]}}, instr_q[21:0]};
      2'b11:   ext_off = {{4{instr_q[27]}}, instr_q[27:0]};
      default: ext_off = 32'd0;
    endcase
  end

  // cond=111 is always-taken in both builds; only the link write differs
  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      3'b000:  cond_met = 1'b0;
      3'b001:  cond_met = 1'b1;
      3'b010:  cond_met = rs_val_q[31];
      3'b011:  cond_met = (rs_val_q == 32'd0);
      3'b100:  cond_met = (rs_val_q != 32'd0);
      3'b101:  cond_met = carry_q;
      3'b110:  cond_met = ~carry_q;
      default: cond_met = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    off_sel_d = off_sel_q;
    cond_d    = cond_q;
    instr_d   = instr_q;
    rs_val_d  = rs_val_q;
    carry_d   = carry_q;
    pc_d      = pc_q;
    taken_d   = taken_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          off_sel_d = bus.off_sel;
          cond_d    = bus.cond;
          instr_d   = bus.instr[27:0];
          rs_val_d  = bus.rs_val;
          carry_d   = bus.carry;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        pc_d    = cond_met ? (seq_pc + (ext_off << 2)) : seq_pc;
        taken_d = cond_met;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (!bus.stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pc_valid_d    = (state_d == UPDATE);
    instr_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      off_sel_q     <= 2'b00;
      cond_q        <= 3'b000;
      instr_q       <= 28'd0;
      rs_val_q      <= 32'd0;
      carry_q       <= 1'b0;
      pc_q          <= RESET_PC;
      taken_q       <= 1'b0;
      pc_valid_q    <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      off_sel_q     <= off_sel_d;
      cond_q        <= cond_d;
      instr_q       <= instr_d;
      rs_val_q      <= rs_val_d;
      carry_q       <= carry_d;
      pc_q          <= pc_d;
      taken_q       <= taken_d;
      pc_valid_q    <= pc_valid_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.taken       = taken_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.instr_ready = instr_ready_q;

`ifdef PCU_LINK_EN
  logic        link_we_q, link_we_d;
  logic [31:0] link_val_q, link_val_d;

  // Strobe is registered on the EVAL edge so it lands in the first UPDATE cycle only
  always_comb begin
    link_we_d  = (state_q == EVAL) && (cond_q == 3'b111);
    link_val_d = link_we_d ? seq_pc : link_val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_we_q  <= 1'b0;
      link_val_q <= 32'd0;
    end else begin
      link_we_q  <= link_we_d;
      link_val_q <= link_val_d;
    end
  end

  assign bus.link_we  = link_we_q;
  assign bus.link_val = link_val_q;
`else
  assign bus.link_we  = 1'b0;
  assign bus.link_val = 32'd0;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed bench for pc_update_ctrl: arithmetic next-PC model, per-cycle compare, literal pins.
module tb_pc_update_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PCU_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_update_ctrl_if bus ();

  pc_update_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int link_cnt = 0;
  logic [31:0] link_seen = 32'd0;
  int last_vcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: offset as a signed integer, PC arithmetic in 64 bits then wrapped
  function automatic longint field_val(input logic [1:0] sel, input logic [31:0] w);
    longint v;
    int width;
    case (sel)
      2'b01:   begin v = longint'(w[15:0]); width = 16; end
      2'b10:   begin v = longint'(w[21:0]); width = 22; end
      2'b11:   begin v = longint'(w[27:0]); width = 28; end
      default: return 0;
    endcase
    if (v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
    return v;
  endfunction

  function automatic logic cond_true(input logic [2:0] c, input logic [31:0] rs, input logic cy);
    case (c)
      3'd0:    return 1'b0;
      3'd1:    return 1'b1;
      3'd2:    return rs[31];
      3'd3:    return rs == 32'd0;
      3'd4:    return rs != 32'd0;
      3'd5:    return cy;
      3'd6:    return !cy;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [1:0] sel,
                                          input logic [31:0] w, input logic ct);
    longint t;
    t = longint'(pc) + 4 + (ct ? 4 * field_val(sel, w) : 0);
    return t[31:0];
  endfunction

  int          m_phase;
  logic [31:0] m_pc, m_link_val, cap_w, cap_rs;
  logic        m_taken, m_link_we, cap_cy;
  logic [1:0]  cap_sel;
  logic [2:0]  cap_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    <= 0;
      m_pc       <= RST_PC;
      m_taken    <= 1'b0;
      m_link_we  <= 1'b0;
      m_link_val <= 32'd0;
    end else begin
      m_link_we <= 1'b0;
      case (m_phase)
        0: if (bus.instr_valid) begin
          cap_sel <= bus.off_sel;
          cap_c   <= bus.cond;
          cap_w   <= bus.instr;
          cap_rs  <= bus.rs_val;
          cap_cy  <= bus.carry;
          m_phase <= 1;
        end
        1: begin
          m_pc    <= predict(m_pc, cap_sel, cap_w, cond_true(cap_c, cap_rs, cap_cy));
          m_taken <= cond_true(cap_c, cap_rs, cap_cy);
          if (LINK && cap_c == 3'd7) begin
            m_link_we  <= 1'b1;
            m_link_val <= m_pc + 32'd4;
          end
          m_phase <= 2;
        end
        default: if (!bus.stall) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ready", bus.instr_ready, 32'(m_phase == 0));
      chk("cyc_pc_valid", bus.pc_valid, 32'(m_phase == 2));
      chk("cyc_pc_out", bus.pc_out, m_pc);
      chk("cyc_taken", bus.taken, m_taken);
      chk("cyc_link_we", bus.link_we, m_link_we);
      chk("cyc_link_val", bus.link_val, m_link_val);
    end
    if (bus.link_we) begin
      link_cnt++;
      link_seen = bus.link_val;
    end
  end

  task automatic do_instr(input logic [1:0] sel, input logic [2:0] c, input logic [31:0] w,
                          input logic [31:0] rs, input logic cy, input int nstall, input bit junk,
                          input logic [31:0] exp_pc, input logic exp_tk);
    int vcnt;
    logic [31:0] pc_hold;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.off_sel     = sel;
    bus.cond        = c;
    bus.instr       = w;
    bus.rs_val      = rs;
    bus.carry       = cy;
    bus.stall       = (nstall > 0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("eval_pc_valid", bus.pc_valid, 32'd0);
    chk("eval_ready", bus.instr_ready, 32'd0);
    @(negedge clk);
    chk("lat_pc_valid", bus.pc_valid, 32'd1);
    chk("pc_out", bus.pc_out, exp_pc);
    chk("model_pc", m_pc, exp_pc);
    chk("taken", bus.taken, 32'(exp_tk));
    pc_hold = bus.pc_out;
    vcnt = 0;
    if (junk) begin
      bus.instr_valid = 1'b1;
      bus.instr       = 32'hDEAD_BEEF;
      bus.cond        = 3'd1;
    end
    for (int i = 0; i < nstall; i++) begin
      if (bus.pc_valid) vcnt++;
      chk("stall_ready", bus.instr_ready, 32'd0);
      chk("stall_pc_hold", bus.pc_out, pc_hold);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    bus.instr_valid = 1'b0;
    if (bus.pc_valid) vcnt++;
    chk("last_pc_hold", bus.pc_out, pc_hold);
    @(negedge clk);
    chk("idle_ready", bus.instr_ready, 32'd1);
    chk("idle_pc_valid", bus.pc_valid, 32'd0);
    last_vcnt = vcnt;
  endtask

  initial begin
    int lc;
    bus.instr_valid = 1'b0;
    bus.off_sel = 2'b00;
    bus.cond = 3'd0;
    bus.instr = 32'd0;
    bus.rs_val = 32'd0;
    bus.carry = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pc_out", bus.pc_out, RST_PC);
    chk("rst_ready", bus.instr_ready, 32'd1);
    chk("rst_pc_valid", bus.pc_valid, 32'd0);
    chk("rst_taken", bus.taken, 32'd0);
    chk("rst_link_we", bus.link_we, 32'd0);
    chk("rst_link_val", bus.link_val, 32'd0);

    do_instr(2'b01, 3'd1, 32'h0000_003F, 32'd0, 1'b0, 0, 1'b0, 32'h100, 1'b1);
    do_instr(2'b11, 3'd1, 32'h0FFF_FFFE, 32'd0, 1'b0, 0, 1'b0, 32'h0FC, 1'b1);
    do_instr(2'b01, 3'd1, 32'h0000_0040, 32'd0, 1'b0, 0, 1'b0, 32'h200, 1'b1);
    do_instr(2'b10, 3'd3, 32'h0000_0010, 32'd5, 1'b0, 0, 1'b0, 32'h204, 1'b0);
    do_instr(2'b01, 3'd1, 32'h0000_FFFE, 32'd0, 1'b0, 0, 1'b0, 32'h200, 1'b1);
    do_instr(2'b10, 3'd3, 32'h0000_0010, 32'd0, 1'b0, 0, 1'b0, 32'h244, 1'b1);
    do_instr(2'b00, 3'd0, 32'h0000_0000, 32'd0, 1'b0, 4, 1'b1, 32'h248, 1'b0);
    chk("stall_valid_cycles", 32'(last_vcnt), 32'd5);
    do_instr(2'b01, 3'd1, 32'h0000_006D, 32'd0, 1'b0, 0, 1'b0, 32'h400, 1'b1);

    lc = link_cnt;
    do_instr(2'b01, 3'd7, 32'h0000_0008, 32'd0, 1'b0, 0, 1'b0, 32'h424, 1'b1);
    chk("link_pulses", 32'(link_cnt - lc), LINK ? 32'd1 : 32'd0);
    chk("link_val", bus.link_val, LINK ? 32'h404 : 32'h0);

    do_instr(2'b00, 3'd1, 32'h0000_1234, 32'd0, 1'b0, 0, 1'b0, 32'h428, 1'b1);
    do_instr(2'b10, 3'd6, 32'h003F_FFFF, 32'd0, 1'b0, 0, 1'b0, 32'h428, 1'b1);
    do_instr(2'b01, 3'd5, 32'h0000_0010, 32'd0, 1'b0, 0, 1'b0, 32'h42C, 1'b0);
    do_instr(2'b01, 3'd5, 32'h0000_0010, 32'd0, 1'b1, 1, 1'b0, 32'h470, 1'b1);
    do_instr(2'b01, 3'd4, 32'h0000_0000, 32'd0, 1'b0, 0, 1'b0, 32'h474, 1'b0);

    // Reset while the controller sits in EVAL with a link instruction captured
    lc = link_cnt;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.off_sel = 2'b01;
    bus.cond = 3'd7;
    bus.instr = 32'h0000_0008;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_out", bus.pc_out, RST_PC);
    chk("mid_rst_pc_valid", bus.pc_valid, 32'd0);
    chk("mid_rst_ready", bus.instr_ready, 32'd1);
    chk("mid_rst_link_we", bus.link_we, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_pc_valid", bus.pc_valid, 32'd0);
      chk("post_rst_ready", bus.instr_ready, 32'd1);
    end
    chk("post_rst_link_pulses", 32'(link_cnt - lc), 32'd0);

    do_instr(2'b01, 3'd2, 32'h0000_8000, 32'h8000_0000, 1'b0, 0, 1'b0, 32'hFFFE_0004, 1'b1);
    do_instr(2'b01, 3'd2, 32'h0000_0004, 32'h7FFF_FFFF, 1'b0, 0, 1'b0, 32'hFFFE_0008, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
